mpa_addsub_stream: RTL

//  Streaming multi-precision integer add/subtract unit for the coprocessor core, next generation of the adder.

---
 rtl/mpa_addsub_stream.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mpa_addsub_stream.sv
// Streaming multi-precision add/subtract unit.
// Two operands are picked from G_NUM_SRC limb sources and combined limb by limb, LSB first.
// Operands may differ in length. The result is max(lenA,lenB)+1 limbs long, and its final
// limb carries the carry (add) or the sign extension (subtract). Results drain through a
// small output FIFO that honours backpressure.

module mpa_addsub_stream #(
   parameter int unsigned G_DATA_WIDTH = 64,
   parameter int unsigned G_CTRL_WIDTH = 8,
   parameter int unsigned G_ID         = 3,
   parameter int unsigned G_NUM_SRC    = 13,
   parameter int unsigned G_MAX_LIMBS  = 512,
   parameter int unsigned G_OUT_DEPTH  = 4
) (
   input  logic                                r_clk,
   input  logic                                r_rst,
   input  logic [G_CTRL_WIDTH-1:0]             pi_ctrl_ch_A,
   input  logic [G_CTRL_WIDTH-1:0]             pi_ctrl_ch_B,
   input  logic                                pi_ctrl_valid_n,
   input  logic [G_NUM_SRC*G_DATA_WIDTH-1:0]   pi_data,
   input  logic                                pi_data_wr_en,
   input  logic                                pi_last_A,
   input  logic                                pi_last_B,
   input  logic                                pi_out_ready,
   output logic                                po_in_ready,
   output logic [G_DATA_WIDTH-1:0]             po_data,
   output logic                                po_data_wr_en,
   output logic                                po_data_last,
   output logic [1:0]                          po_data_zero,
   output logic                                po_data_all_ones,
   output logic                                po_flags_valid,
   output logic                                po_cmd_err,
   output logic                                po_overflow,
   output logic                                po_busy
);

   localparam int unsigned DW     = G_DATA_WIDTH;
   localparam int unsigned CNT_W  = $clog2(G_OUT_DEPTH + 1);
   localparam int unsigned FILL_W = CNT_W + 1;
   localparam int unsigned PTR_W  = (G_OUT_DEPTH > 1) ? $clog2(G_OUT_DEPTH) : 1;
   localparam int unsigned LIMB_W = $clog2(G_MAX_LIMBS + 1);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(G_OUT_DEPTH - 2);
   localparam logic [LIMB_W-1:0] LIMB_MAX = LIMB_W'(G_MAX_LIMBS);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(G_OUT_DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StCtrl2, StRun, StTail, StFlags} state_t;
   typedef enum logic [1:0] {OpAdd, OpSub, OpRsub, OpAdd1} op_t;

   // Control / datapath state
   state_t                  state_q;
   op_t                     op_q;
   logic [G_CTRL_WIDTH-1:0] src_a_q;
   logic [G_CTRL_WIDTH-1:0] src_b_q;
   logic                    seen_a_q;
   logic                    seen_b_q;
   logic                    carry_q;
   logic [LIMB_W-1:0]       limb_cnt_q;
   logic                    main_zero_q;
   logic                    main_ones_q;
   logic                    pipe_vld_q;
   logic                    pipe_last_q;
   logic [DW-1:0]           pipe_data_q;
   logic                    cmd_err_q;
   logic                    overflow_q;
   logic                    flags_vld_q;
   logic [1:0]              zero_q;
   logic                    ones_q;

   // Output FIFO
   logic [DW:0]             mem_q [G_OUT_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        fifo_cnt_q;

   logic                    id_hit;
   logic                    is_sub;
   logic [DW-1:0]           limb_a;
   logic [DW-1:0]           limb_b;
   logic [DW-1:0]           opd_a;
   logic [DW-1:0]           opd_b;
   logic [DW-1:0]           opx;
   logic [DW-1:0]           opy;
   logic [DW:0]             sum;
   logic [DW-1:0]           ext_limb;
   logic                    ext_zero;
   logic                    done_a;
   logic                    done_b;
   logic [FILL_W-1:0]       fill;
   logic                    in_ready;
   logic                    beat_ok;
   logic                    beat_drop;
   logic                    ctrl_bad;
   logic [LIMB_W-1:0]       limb_cnt_nxt;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;
   logic [PTR_W-1:0]        wr_ptr_nxt;
   logic [PTR_W-1:0]        rd_ptr_nxt;

   assign id_hit = !pi_ctrl_valid_n && (pi_ctrl_ch_A[5:0] == 6'(G_ID));
   assign is_sub = (op_q == OpSub) || (op_q == OpRsub);

   // Source multiplexers for the latched A and B indices
   always_comb begin
      limb_a = '0;
      limb_b = '0;
      for (int k = 0; k < G_NUM_SRC; k++) begin
         if (src_a_q == G_CTRL_WIDTH'(k)) limb_a = pi_data[k*DW +: DW];
         if (src_b_q == G_CTRL_WIDTH'(k)) limb_b = pi_data[k*DW +: DW];
      end
   end

   // Operand shaping: exhausted operands read as zero, subtrahend is inverted
   always_comb begin
      opd_a = seen_a_q ? '0 : limb_a;
      opd_b = seen_b_q ? '0 : limb_b;
      opx   = opd_a;
      opy   = opd_b;
      unique case (op_q)
         OpAdd, OpAdd1: begin
            opx = opd_a;
            opy = opd_b;
         end
         OpSub: begin
            opx = opd_a;
            opy = ~opd_b;
         end
         OpRsub: begin
            opx = opd_b;
            opy = ~opd_a;
         end
         default: ;
      endcase
   end

   assign sum = {1'b0, opx} + {1'b0, opy} + {{DW{1'b0}}, carry_q};

   // Extension limb: carry for add, sign (borrow = no carry out) for subtract
   assign ext_limb = is_sub ? {DW{~carry_q}} : {{(DW-1){1'b0}}, carry_q};
   assign ext_zero = is_sub ? carry_q : ~carry_q;

   assign done_a = seen_a_q | pi_last_A;
   assign done_b = seen_b_q | pi_last_B;

   // Occupancy includes the limb sitting in the push stage, so the TAIL push always finds room
   assign fill      = FILL_W'(fifo_cnt_q) + FILL_W'(pipe_vld_q);
   assign in_ready  = (state_q == StRun) && (fill <= FILL_MAX);
   assign beat_ok   = pi_data_wr_en && in_ready;
   assign beat_drop = (state_q == StRun) && pi_data_wr_en && !in_ready;
   assign ctrl_bad  = pi_ctrl_valid_n ||
                      (32'(pi_ctrl_ch_A) >= G_NUM_SRC) ||
                      (32'(pi_ctrl_ch_B) >= G_NUM_SRC);
   assign limb_cnt_nxt = limb_cnt_q + LIMB_W'(1);

   // Command FSM and limb datapath
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         state_q     <= StIdle;
         op_q        <= OpAdd;
         src_a_q     <= '0;
         src_b_q     <= '0;
         seen_a_q    <= 1'b0;
         seen_b_q    <= 1'b0;
         carry_q     <= 1'b0;
         limb_cnt_q  <= '0;
         main_zero_q <= 1'b0;
         main_ones_q <= 1'b0;
         pipe_vld_q  <= 1'b0;
         pipe_last_q <= 1'b0;
         pipe_data_q <= '0;
         cmd_err_q   <= 1'b0;
         overflow_q  <= 1'b0;
         flags_vld_q <= 1'b0;
         zero_q      <= 2'b00;
         ones_q      <= 1'b0;
      end else begin
         cmd_err_q   <= 1'b0;
         flags_vld_q <= 1'b0;
         pipe_vld_q  <= 1'b0;
         if (beat_drop) overflow_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (id_hit) begin
                  op_q    <= op_t'(pi_ctrl_ch_A[7:6]);
                  state_q <= StCtrl2;
               end
            end
            StCtrl2: begin
               if (ctrl_bad) begin
                  cmd_err_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  src_a_q     <= pi_ctrl_ch_A;
                  src_b_q     <= pi_ctrl_ch_B;
                  overflow_q  <= 1'b0;
                  carry_q     <= (op_q != OpAdd);
                  seen_a_q    <= 1'b0;
                  seen_b_q    <= 1'b0;
                  limb_cnt_q  <= '0;
                  main_zero_q <= 1'b1;
                  main_ones_q <= 1'b1;
                  state_q     <= StRun;
               end
            end
            StRun: begin
               if (id_hit) cmd_err_q <= 1'b1;
               if (beat_ok) begin
                  pipe_vld_q  <= 1'b1;
                  pipe_last_q <= 1'b0;
                  pipe_data_q <= sum[DW-1:0];
                  carry_q     <= sum[DW];
                  seen_a_q    <= done_a;
                  seen_b_q    <= done_b;
                  limb_cnt_q  <= limb_cnt_nxt;
                  main_zero_q <= main_zero_q & (sum[DW-1:0] == '0);
                  main_ones_q <= main_ones_q & (&sum[DW-1:0]);
                  if (done_a && done_b) begin
                     state_q <= StTail;
                  end else if (limb_cnt_nxt == LIMB_MAX) begin
                     cmd_err_q <= 1'b1;
                     state_q   <= StTail;
                  end
               end
            end
            StTail: begin
               if (id_hit) cmd_err_q <= 1'b1;
               pipe_vld_q  <= 1'b1;
               pipe_last_q <= 1'b1;
               pipe_data_q <= ext_limb;
               zero_q      <= {is_sub & ~carry_q, main_zero_q & ext_zero};
               ones_q      <= main_ones_q;
               flags_vld_q <= 1'b1;
               state_q     <= StFlags;
            end
            StFlags: begin
               if (id_hit) cmd_err_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign fifo_empty = (fifo_cnt_q == '0);
   assign push       = pipe_vld_q;
   assign pop        = !fifo_empty && pi_out_ready;
   assign wr_ptr_nxt = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
   assign rd_ptr_nxt = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

   // FIFO pointers and occupancy
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_nxt;
         if (pop)  rd_ptr_q <= rd_ptr_nxt;
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
         else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
      end
   end

   // FIFO storage; contents are only visible through the non-empty gate below
   always_ff @(posedge r_clk) begin
      if (push) mem_q[wr_ptr_q] <= {pipe_last_q, pipe_data_q};
   end

   assign po_in_ready      = in_ready;
   assign po_data_wr_en    = !fifo_empty;
   assign po_data          = fifo_empty ? '0 : mem_q[rd_ptr_q][DW-1:0];
   assign po_data_last     = !fifo_empty && mem_q[rd_ptr_q][DW];
   assign po_data_zero     = zero_q;
   assign po_data_all_ones = ones_q;
   assign po_flags_valid   = flags_vld_q;
   assign po_cmd_err       = cmd_err_q;
   assign po_overflow      = overflow_q;
   assign po_busy          = (state_q != StIdle);

endmodule
